// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: single-outstanding arbiter between instruction fetch and
// the load/store buffer, feeding a byte-serial memory controller. LS wins by
// default, fetch is aged against starvation, fetch is cancelled on a jump,
// and stores to the UART IO region are paced against io_buffer_full.
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int IO_GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        jump_flag,
  input  logic        io_buffer_full,
  output logic        mc_valid,
  output logic [31:0] mc_addr,
  output logic        mc_wr,
  output logic [2:0]  mc_size,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int GW = (IO_GAP < 1) ? 1 : $clog2(IO_GAP + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(IO_GAP);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          mc_valid_q, mc_valid_d;
  logic [31:0]   mc_addr_q, mc_addr_d;
  logic          mc_wr_q, mc_wr_d;
  logic [2:0]    mc_size_q, mc_size_d;
  logic [31:0]   mc_wdata_q, mc_wdata_d;
  logic          if_done_q, if_done_d;
  logic [31:0]   if_inst_q, if_inst_d;
  logic          ls_done_q, ls_done_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          cur_io_q, cur_io_d;

  logic io_addr;
  logic io_blocked;
  logic ls_elig;
  logic if_elig;
  logic arb_en;
  logic grant_if;
  logic grant_ls;
  logic if_flush;

  // Arbitration is skipped in the cycle a done pulse is visible, so the
  // requester that just completed has a cycle to retire its level-held valid.
  assign io_addr    = (ls_addr[17:16] == 2'b11);
  assign io_blocked = ls_valid & ls_wr & io_addr & (io_buffer_full | (gap_q != '0));
  assign ls_elig    = ls_valid & ~io_blocked;
  assign if_elig    = if_valid & ~jump_flag;
  assign arb_en     = (state_q == IDLE) & ~if_done_q & ~ls_done_q;
  assign grant_if   = arb_en & if_elig & ((starve_q == STARVE_MAX) | ~ls_elig);
  assign grant_ls   = arb_en & ls_elig & ~grant_if;
  assign if_flush   = jump_flag | ~if_valid;

  // Next-state, next-output and counter computation for the arbiter FSM.
  always_comb begin
    state_d    = state_q;
    mc_valid_d = mc_valid_q;
    mc_addr_d  = mc_addr_q;
    mc_wr_d    = mc_wr_q;
    mc_size_d  = mc_size_q;
    mc_wdata_d = mc_wdata_q;
    if_done_d  = 1'b0;
    if_inst_d  = if_inst_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    starve_d   = starve_q;
    cur_io_d   = cur_io_q;
    gap_d      = (gap_q != '0) ? gap_q - 1'b1 : gap_q;

    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d    = BUSY_IF;
          mc_valid_d = 1'b1;
          mc_addr_d  = if_addr;
          mc_wr_d    = 1'b0;
          mc_size_d  = 3'd4;
          mc_wdata_d = 32'h0;
          starve_d   = '0;
        end else if (grant_ls) begin
          state_d    = BUSY_LS;
          mc_valid_d = 1'b1;
          mc_addr_d  = ls_addr;
          mc_wr_d    = ls_wr;
          mc_size_d  = ls_size;
          mc_wdata_d = ls_wdata;
          cur_io_d   = ls_wr & io_addr;
          if (if_valid) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (!if_valid) begin
          starve_d = '0;
        end
      end
      BUSY_LS: begin
        if (mc_done) begin
          state_d    = IDLE;
          mc_valid_d = 1'b0;
          ls_done_d  = 1'b1;
          ls_rdata_d = mc_wr_q ? 32'h0 : mc_rdata;
          if (cur_io_q) begin
            gap_d = GAP_LOAD;
          end
        end
      end
      BUSY_IF: begin
        if (mc_done) begin
          state_d    = IDLE;
          mc_valid_d = 1'b0;
          if (!if_flush) begin
            if_done_d = 1'b1;
            if_inst_d = mc_rdata;
          end
        end else if (if_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mc_done) begin
          state_d    = IDLE;
          mc_valid_d = 1'b0;
        end
      end
    endcase
  end

  // State register: synchronous reset, everything frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mc_valid_q <= 1'b0;
      mc_addr_q  <= 32'h0;
      mc_wr_q    <= 1'b0;
      mc_size_q  <= 3'd0;
      mc_wdata_q <= 32'h0;
      if_done_q  <= 1'b0;
      if_inst_q  <= 32'h0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= 32'h0;
      starve_q   <= '0;
      gap_q      <= '0;
      cur_io_q   <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      mc_valid_q <= mc_valid_d;
      mc_addr_q  <= mc_addr_d;
      mc_wr_q    <= mc_wr_d;
      mc_size_q  <= mc_size_d;
      mc_wdata_q <= mc_wdata_d;
      if_done_q  <= if_done_d;
      if_inst_q  <= if_inst_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
      starve_q   <= starve_d;
      gap_q      <= gap_d;
      cur_io_q   <= cur_io_d;
    end
  end

  assign mc_valid = mc_valid_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wr    = mc_wr_q;
  assign mc_size  = mc_size_q;
  assign mc_wdata = mc_wdata_q;
  assign if_done  = if_done_q;
  assign if_inst  = if_inst_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates memory access between the instruction-fetch requester (icache) and the load/store requester (LSB).
- Issues one transaction at a time to the byte-serial memory controller.
- Applies LSB-first priority with anti-starvation aging for fetch, cancels fetch on jump, and paces stores to the UART IO region against io_buffer_full.
- Sits between the icache/LSB and the memory controller; routes each completion back to the requester that owns it.

Parameters:
- STARVE_LIMIT, 4: consecutive LS grants made while a fetch is pending; once reached, fetch wins the next arbitration.
- IO_GAP, 2: minimum idle cycles after an IO store completes before another IO store may be granted.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global ready; low freezes the block
- if_valid  in  1  fetch request, level-held until if_done or withdrawn
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle completion pulse to fetch
- if_inst  out  32  fetched word, valid while if_done=1
- ls_valid  in  1  load/store request, level-held until ls_done
- ls_wr  in  1  1=store, 0=load
- ls_addr  in  32  load/store address
- ls_size  in  3  byte count: 1, 2 or 4
- ls_wdata  in  32  store data
- ls_done  out  1  one-cycle completion pulse to LSB
- ls_rdata  out  32  load data, valid while ls_done=1
- jump_flag  in  1  pipeline flush; cancels fetch only
- io_buffer_full  in  1  UART transmit buffer full
- mc_valid  out  1  transaction request to memory controller, held until mc_done
- mc_addr  out  32  transaction address
- mc_wr  out  1  transaction direction
- mc_size  out  3  byte count; 4 for fetch
- mc_wdata  out  32  store data
- mc_done  in  1  one-cycle completion from memory controller
- mc_rdata  in  32  read data, valid with mc_done

Behaviour:
Reset and rdy:
- rst is synchronous, active-high; clock is clk.
- Reset values: all outputs 0; state IDLE; starve counter 0; IO gap counter 0.
- rst mid-transaction abandons it with no done pulse. The memory controller is reset by the same rst.
- rdy=0: all registers hold, including outputs. mc_done is not sampled while rdy=0.

Address classification:
- IO address = ls_addr[17:16]==2'b11.
- IO-blocked store = ls_valid & ls_wr & IO address & (io_buffer_full | gap counter != 0).

State machine (IDLE, BUSY_IF, BUSY_LS, DRAIN):
- IDLE, arbitration each cycle:
  - ls_eligible = ls_valid & ~IO-blocked.
  - if_eligible = if_valid & ~jump_flag.
  - If the starve counter == STARVE_LIMIT and if_eligible: grant IF.
  - Else if ls_eligible: grant LS.
  - Else if if_eligible: grant IF.
- Grant takes effect at the clock edge; mc_valid=1 from the next cycle.
  - mc_* latch the winner's fields. IF grant sets mc_wr=0 and mc_size=4.
  - Next state is BUSY_IF or BUSY_LS.
- mc_* fields stay stable while mc_valid=1.
- BUSY_LS: on mc_done, set mc_valid=0, pulse ls_done, register ls_rdata from mc_rdata (zero for stores), return to IDLE.
  - If the transaction was an IO store, load the gap counter with IO_GAP.
- BUSY_IF: on mc_done, set mc_valid=0, pulse if_done with if_inst, return to IDLE.
  - jump_flag=1 in BUSY_IF without mc_done: go to DRAIN.
  - jump_flag=1 on the same cycle as mc_done: suppress if_done, go to IDLE.
- DRAIN: mc_valid stays 1 until mc_done; no if_done is pulsed; then IDLE. The memory controller always finishes a started transaction.
- Done pulses last exactly one cycle. There is at least one IDLE cycle between transactions.

Counters:
- Starve counter:
  - +1 on each LS grant made while if_valid=1, saturating at STARVE_LIMIT.
  - Cleared on an IF grant or whenever if_valid=0 in IDLE.
- Gap counter:
  - Decrements by 1 each rdy cycle while nonzero.
  - Blocks only IO stores. IO loads and non-IO accesses are never blocked; a blocked LS lets a pending IF proceed.

Other rules:
- jump_flag never affects LS requests in any state.
- if_valid withdrawn while BUSY_IF is handled as a flush: transition to DRAIN.
- A requester dropping valid before grant is simply not granted.

Test Plan:
- Lone fetch: if_valid, if_addr=0x100 in IDLE -> mc_valid next cycle with addr 0x100, wr 0, size 4; mc_done with rdata 0xDEADBEEF -> if_done 1 cycle later, if_inst=0xDEADBEEF.
- Simultaneous requests: if_valid and ls_valid (load 0x2000, size 4) in the same cycle -> LS granted first, IF granted after ls_done; order LS, IF.
- Starvation: if_valid held with 5 back-to-back LS loads, STARVE_LIMIT=4 -> grants LS, LS, LS, LS, IF, LS; starve counter returns to 0.
- Flush: jump_flag during BUSY_IF -> DRAIN, mc_valid held, no if_done after mc_done; a new fetch to 0x200 is granted normally afterwards.
- IO pacing: store to 0x30000 with io_buffer_full=1 for 6 cycles and if_valid=1 -> IF served meanwhile; store granted after full drops; a second IO store waits ≥2 idle cycles after the first ls_done.
- rdy freeze: rdy=0 for 3 cycles in BUSY_LS with mc_done asserted during the freeze -> all outputs unchanged, no ls_done; the completion occurs only on an mc_done received with rdy=1.
